// File: rtl/uart_loader_pkg.sv
// Shared types and defaults for the boot-time UART program loader.
package uart_loader_pkg;

    localparam int DATA_WID = 32;

    localparam logic [DATA_WID-1:0] LOADER_BASE       = 32'h0000_0000;
    localparam int                  LOADER_WORD_LIMIT = 16384;
    localparam int                  LOADER_TIMEOUT    = 5_000_000;

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_DRAIN,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    // Next word-aligned address; wraps naturally at 2^DATA_WID.
    function automatic logic [DATA_WID-1:0] next_word_addr(input logic [DATA_WID-1:0] a);
        return a + DATA_WID'(4);
    endfunction

endpackage

// File: rtl/uart_loader_word_assembler.sv
// Collects little-endian bytes into 32-bit words. The word is presented
// combinationally on the cycle its 4th byte arrives so the loader can act on
// it at the very next edge.
module word_assembler
    import uart_loader_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                byte_valid_i,
    input  logic [7:0]          byte_i,
    output logic                word_valid_o,
    output logic [DATA_WID-1:0] word_o,
    output logic [1:0]          idx_o
);

    logic [1:0]  idx_q;
    logic [23:0] low_q;

    // Byte index and storage for the three low bytes of the word in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= 2'd0;
            low_q <= 24'd0;
        end else if (clear_i) begin
            idx_q <= 2'd0;
            low_q <= 24'd0;
        end else if (byte_valid_i) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
                2'd0:    low_q[7:0]   <= byte_i;
                2'd1:    low_q[15:8]  <= byte_i;
                2'd2:    low_q[23:16] <= byte_i;
                default: ;
            endcase
        end
    end

    assign word_valid_o = byte_valid_i && !clear_i && (idx_q == 2'd3);
    assign word_o       = {byte_i, low_q};
    assign idx_o        = idx_q;

endmodule

// File: rtl/uart_loader.sv
// Boot loader: reads a length-prefixed little-endian image from the UART and
// writes it word by word through memory port B, then releases the core.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter logic [DATA_WID-1:0] BASE_ADDR  = LOADER_BASE,
    parameter int                  WORD_LIMIT = LOADER_WORD_LIMIT,
    parameter int                  TIMEOUT    = LOADER_TIMEOUT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rx_valid_i,
    input  logic [7:0]          rx_byte_i,
    input  logic                start_i,
    output logic [DATA_WID-1:0] uart_addr_o,
    output logic [DATA_WID-1:0] uart_data_o,
    output logic                uart_we_o,
    output logic                uart_done_o,
    output logic                err_o,
    output logic [DATA_WID-1:0] words_loaded_o
);

    localparam logic [DATA_WID-1:0] LIMIT_W = DATA_WID'(WORD_LIMIT);
    localparam logic [DATA_WID-1:0] TOUT_W  = DATA_WID'(TIMEOUT);

    loader_state_e       state_q;
    logic [DATA_WID-1:0] addr_q, data_q, words_q, remain_q, idle_q;
    logic                we_q, done_q, err_q;

    logic                byte_acc;
    logic                word_valid;
    logic [DATA_WID-1:0] word;
    logic [1:0]          byte_idx;
    logic                idle_run;

    // A restart pulse always beats a coincident byte.
    assign byte_acc = rx_valid_i && !start_i &&
                      ((state_q == ST_LEN) || (state_q == ST_DATA));

    // Idle timer only runs once a load has visibly begun.
    assign idle_run = (state_q == ST_DATA) ||
                      ((state_q == ST_LEN) && (byte_idx != 2'd0));

    word_assembler u_asm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (start_i),
        .byte_valid_i (byte_acc),
        .byte_i       (rx_byte_i),
        .word_valid_o (word_valid),
        .word_o       (word),
        .idx_o        (byte_idx)
    );

    // Loader FSM with its counters, address and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_LEN;
            addr_q   <= BASE_ADDR;
            data_q   <= '0;
            words_q  <= '0;
            remain_q <= '0;
            idle_q   <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;

            // The cycle after a strobe, step to the next word slot.
            if (we_q) begin
                addr_q  <= next_word_addr(addr_q);
                words_q <= words_q + DATA_WID'(1);
            end

            if (start_i) begin
                state_q  <= ST_LEN;
                addr_q   <= BASE_ADDR;
                words_q  <= '0;
                remain_q <= '0;
                idle_q   <= '0;
                done_q   <= 1'b0;
                err_q    <= 1'b0;
            end else begin
                if (byte_acc) begin
                    idle_q <= '0;
                end else if (idle_run) begin
                    idle_q <= idle_q + DATA_WID'(1);
                    if (idle_q + DATA_WID'(1) == TOUT_W) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                    end
                end else begin
                    idle_q <= '0;
                end

                case (state_q)
                    ST_LEN: begin
                        if (word_valid) begin
                            if (word == '0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else if (word > LIMIT_W) begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end else begin
                                state_q  <= ST_DATA;
                                remain_q <= word;
                                addr_q   <= BASE_ADDR;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (word_valid) begin
                            data_q   <= word;
                            we_q     <= 1'b1;
                            remain_q <= remain_q - DATA_WID'(1);
                            if (remain_q == DATA_WID'(1)) begin
                                state_q <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign uart_addr_o    = addr_q;
    assign uart_data_o    = data_q;
    assign uart_we_o      = we_q;
    assign uart_done_o    = done_q;
    assign err_o          = err_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: exact-timing sequences, a table of load images and a
// write scoreboard fed as data bytes are driven.
module tb_uart_loader;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          LIMIT = 8;
    localparam int          TOUT  = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        start = 1'b0;
    logic [31:0] addr, data, words;
    logic        we, done, err;

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [31:0] hdr;
        int          nsend;
        bit          writes;
        bit          exp_done;
        bit          exp_err;
        int          exp_words;
    } vec_t;
    vec_t vt[7];

    int n_cmp = 0;
    int n_bad = 0;

    uart_loader #(.BASE_ADDR(BASE), .WORD_LIMIT(LIMIT), .TIMEOUT(TOUT)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .rx_valid_i     (rx_valid),
        .rx_byte_i      (rx_byte),
        .start_i        (start),
        .uart_addr_o    (addr),
        .uart_data_o    (data),
        .uart_we_o      (we),
        .uart_done_o    (done),
        .err_o          (err),
        .words_loaded_o (words)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected write.
    wr_t e_wr;
    always @(negedge clk) begin
        if (rst_n && we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_we: addr 0x%08h data 0x%08h with no write expected", addr, data);
            end else begin
                e_wr = exp_q.pop_front();
                check("wr_addr", addr, e_wr.a);
                check("wr_data", data, e_wr.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit push, input logic [31:0] a);
        wr_t x;
        if (push) begin
            x.a = a;
            x.d = w;
            exp_q.push_back(x);
        end
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    function automatic logic [31:0] wgen(input int v, input int i);
        return 32'h5A00_0000 ^ 32'(v * 4096 + i * 17 + 3);
    endfunction

    initial begin
        vt[0] = '{32'd1,          1, 1'b1, 1'b1, 1'b0, 1};
        vt[1] = '{32'd3,          3, 1'b1, 1'b1, 1'b0, 3};
        vt[2] = '{32'd8,          8, 1'b1, 1'b1, 1'b0, 8};
        vt[3] = '{32'd9,          2, 1'b0, 1'b0, 1'b1, 0};
        vt[4] = '{32'd0,          2, 1'b0, 1'b1, 1'b0, 0};
        vt[5] = '{32'h0100_0000,  1, 1'b0, 1'b0, 1'b1, 0};
        vt[6] = '{32'd2,          2, 1'b1, 1'b1, 1'b0, 2};

        // Reset values, held across a few clocks.
        idle(3);
        check("rst_addr", addr, BASE);
        check("rst_data", data, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_words", words, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Two-word image with exact strobe and done timing.
        send_word(32'd2, 1'b0, 32'd0);
        send_word(32'h1122_3344, 1'b1, BASE);
        check("tp_we1", {31'd0, we}, 32'd1);
        check("tp_addr1", addr, BASE);
        check("tp_data1", data, 32'h1122_3344);
        send_word(32'hAABB_CCDD, 1'b1, BASE + 32'd4);
        check("tp_we2", {31'd0, we}, 32'd1);
        check("tp_addr2", addr, BASE + 32'd4);
        check("tp_done_t1", {31'd0, done}, 32'd0);
        idle(1);
        check("tp_done_t2", {31'd0, done}, 32'd1);
        check("tp_words", words, 32'd2);
        check("tp_we_off", {31'd0, we}, 32'd0);

        // Zero-length header: done one cycle after the 4th length byte.
        pulse_start();
        check("z_done_clr", {31'd0, done}, 32'd0);
        check("z_words_clr", words, 32'd0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("z_done_early", {31'd0, done}, 32'd0);
        send_byte(8'h00);
        check("z_done", {31'd0, done}, 32'd1);

        // Oversize header: error one cycle after the offending byte.
        pulse_start();
        send_word(32'(LIMIT + 1), 1'b0, 32'd0);
        check("ov_err", {31'd0, err}, 32'd1);
        check("ov_done", {31'd0, done}, 32'd0);
        send_word(32'hDEAD_BEEF, 1'b0, 32'd0);
        idle(2);
        check("ov_err_hold", {31'd0, err}, 32'd1);

        // Table of images.
        for (int v = 0; v < 7; v++) begin
            pulse_start();
            send_word(vt[v].hdr, 1'b0, 32'd0);
            for (int i = 0; i < vt[v].nsend; i++)
                send_word(wgen(v, i), vt[v].writes, BASE + 32'(4 * i));
            idle(3);
            check($sformatf("v%0d_done", v), {31'd0, done}, {31'd0, vt[v].exp_done});
            check($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, vt[v].exp_err});
            check($sformatf("v%0d_words", v), words, 32'(vt[v].exp_words));
            check($sformatf("v%0d_addr", v), addr, BASE + 32'(4 * vt[v].exp_words));
            check($sformatf("v%0d_pending", v), 32'(exp_q.size()), 32'd0);
        end

        // Timeout after two data bytes, then re-arm and load.
        pulse_start();
        send_word(32'd1, 1'b0, 32'd0);
        send_byte(8'h78); send_byte(8'h56);
        idle(TOUT - 2);
        check("to_err_early", {31'd0, err}, 32'd0);
        idle(4);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_done", {31'd0, done}, 32'd0);
        pulse_start();
        check("to_err_clr", {31'd0, err}, 32'd0);
        send_word(32'd1, 1'b0, 32'd0);
        send_word(32'h1234_5678, 1'b1, BASE);
        idle(2);
        check("to_reload_done", {31'd0, done}, 32'd1);
        check("to_reload_err", {31'd0, err}, 32'd0);

        // Abort mid-word with a coincident byte, then a fresh image.
        pulse_start();
        send_word(32'd2, 1'b0, 32'd0);
        send_word(32'hCAFE_F00D, 1'b1, BASE);
        send_byte(8'hEE); send_byte(8'hFF);
        rx_valid = 1'b1; rx_byte = 8'h99; start = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0; start = 1'b0;
        check("ab_addr", addr, BASE);
        check("ab_words", words, 32'd0);
        send_word(32'd1, 1'b0, 32'd0);
        send_word(32'h1234_5678, 1'b1, BASE);
        idle(2);
        check("ab_done", {31'd0, done}, 32'd1);
        check("ab_words_fin", words, 32'd1);

        // Bytes arriving in DONE are ignored.
        for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i));
        idle(2);
        check("dn_done", {31'd0, done}, 32'd1);
        check("dn_addr", addr, BASE + 32'd4);
        check("dn_data", data, 32'h1234_5678);
        check("dn_words", words, 32'd1);

        // Asynchronous reset in the middle of DATA.
        pulse_start();
        send_word(32'd3, 1'b0, 32'd0);
        send_word(32'h0BAD_F00D, 1'b1, BASE);
        send_byte(8'h01); send_byte(8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_addr", addr, BASE);
        check("ar_data", data, 32'd0);
        check("ar_we", {31'd0, we}, 32'd0);
        check("ar_done", {31'd0, done}, 32'd0);
        check("ar_err", {31'd0, err}, 32'd0);
        check("ar_words", words, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        check("final_pending", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
# uart_loader

Boot-time program loader that owns memory port B while the core is held in reset. It receives a length-prefixed little-endian byte stream from the UART receiver and assembles 32-bit words. It drives `uart_addr`, `uart_data` and a write strobe into the core's UART-select mux. When the image is complete it raises `uart_done`, which releases the core from reset and returns port B to the MEM stage.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first loaded word.
- `WORD_LIMIT`, default 16384: maximum accepted word count. A larger header is an error.
- `TIMEOUT`, default 5_000_000: idle cycles allowed between bytes once a load has begun.
- `clk`  in  1  system clock. One clock domain; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_valid`  in  1  one-cycle pulse: `rx_byte` is valid.
- `rx_byte`  in  8  received byte.
- `start`  in  1  one-cycle re-arm pulse (debounced button).
- `uart_addr`  out  `DATA_WID`  word-aligned write address.
- `uart_data`  out  `DATA_WID`  assembled write data.
- `uart_we`  out  1  one-cycle write strobe.
- `uart_done`  out  1  image loaded; core may run.
- `err`  out  1  sticky error (oversize header or timeout).
- `words_loaded`  out  `DATA_WID`  count of words written in the current load.

## Operation
- States: LEN, DATA, DRAIN, DONE, ERR. Reset enters LEN.
- Byte acceptance:
  - A byte is accepted on any cycle with `rx_valid`=1 in LEN or DATA.
  - Byte k of a word (k=0..3) lands in bits [8k+7:8k], little-endian.
  - A 2-bit byte index wraps 3→0.
- LEN state:
  - The first 4 bytes form word count N.
  - N=0 → DONE.
  - N>`WORD_LIMIT` → ERR.
  - Otherwise → DATA, with the remaining-word counter set to N and `uart_addr` set to `BASE_ADDR`.
- DATA state:
  - On the 4th byte of a word, the next cycle has `uart_data`=assembled word, `uart_we`=1 and `uart_addr` equal to the address for that word.
  - After the strobe, `uart_addr` advances by 4 with 32-bit wrap, and `words_loaded` increments.
  - When the last word is accepted → DRAIN.
- DRAIN state: lasts one cycle, covering the last write strobe, then → DONE.
- DONE state:
  - `uart_done`=1 and `rx_valid` is ignored.
  - `start` → LEN: clears `uart_done`, `words_loaded` and the byte index.
- ERR state:
  - `err`=1, `uart_done`=0, bytes are ignored.
  - `start` → LEN and clears `err`.
- `start` in LEN/DATA/DRAIN: aborts the load and restarts at LEN. The partial word is discarded and `uart_addr` returns to `BASE_ADDR`.
- `start` and `rx_valid` in the same cycle: `start` wins and the byte is dropped.
- Timeout:
  - The idle counter runs only in LEN after at least one byte has been accepted, and in DATA.
  - An accepted byte clears it to 0.
  - When it reaches `TIMEOUT` → ERR.
  - Before the first byte of a load there is no timeout.
- `uart_addr` and `uart_data` hold their values between strobes. Downstream may sample them on any cycle.

## Timing
- Reset values:
  - `uart_addr`=`BASE_ADDR`, `uart_data`=0.
  - `uart_we`=0, `uart_done`=0, `err`=0, `words_loaded`=0.
  - Byte index 0, idle counter 0.
- Strobe latency: `uart_we` is high exactly 1 cycle after the 4th byte's `rx_valid` cycle, for 1 cycle.
- Last word:
  - Strobe at cycle t+1, where t is the cycle of its last byte.
  - DRAIN occupies t+1, and `uart_done` rises at t+2.
- N=0: `uart_done` rises 1 cycle after the 4th length byte.
- Error: `err` rises 1 cycle after the offending length byte, or on the cycle the idle counter reaches `TIMEOUT`.
- Reset mid-load: all outputs return to reset values immediately, without waiting for a clock edge.
- Back-to-back `rx_valid` on consecutive cycles is supported with no bytes lost.

## Structure
- Add to `Const.svh`:
  - the loader state typedef (LEN, DATA, DRAIN, DONE, ERR);
  - the `LOADER_BASE`, `LOADER_WORD_LIMIT` and `LOADER_TIMEOUT` defaults;
  - reuse of `DATA_WID`.
- One natural sub-module, `word_assembler`. It holds the byte index and the shift/insert register, and emits `word_valid` plus `word` with a clear input. The FSM, counters and address live in `uart_loader`.

## Test plan
- Header 02 00 00 00, then 44 33 22 11 DD CC BB AA:
  - First strobe: addr 0x0, data 0x11223344.
  - Second strobe: addr 0x4, data 0xAABBCCDD.
  - `words_loaded`=2.
  - `uart_done`=1 two cycles after the final byte.
- Header 00 00 00 00: no `uart_we`; `uart_done`=1 one cycle after the 4th byte.
- Header encoding `WORD_LIMIT`+1: `err`=1, `uart_done` stays 0, and subsequent bytes produce no strobe.
- Timeout and re-arm:
  - Header 01 00 00 00, data bytes 78 56, then idle `TIMEOUT` cycles: `err`=1.
  - `start`, then a full 1-word image 78 56 34 12: strobe with data 0x12345678 at addr 0x0; `err`=0.
- Abort mid-word: mid-DATA `start` coincident with `rx_valid`, then a fresh 1-word image: strobe addr equals `BASE_ADDR` and no partial-word bytes leak.
- DONE stability:
  - `rx_valid` bursts in DONE: no strobe, outputs unchanged.
  - `rst_n` low mid-DATA: outputs reset asynchronously.
